// File: rtl/siso_shift_reg_pkg.sv
// siso_shift_reg_pkg: shared constants for the serial-in serial-out shift register
package siso_shift_reg_pkg;
    localparam int SISO_DEFAULT_DEPTH = 4;
endpackage

// File: rtl/siso_stage.sv
// siso_stage: one D flip-flop with asynchronous active-high clear
module siso_stage (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else     q <= d;
endmodule

// File: rtl/siso_shift_reg.sv
// siso_shift_reg: DEPTH-stage serial bit delay line built from chained siso_stage flops
module siso_shift_reg
    import siso_shift_reg_pkg::*;
#(
    parameter int DEPTH = SISO_DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);
    logic [DEPTH:0] chain_q;
    assign chain_q[0] = in;
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        siso_stage u_stage (
            .clk (clk),
            .rst (rst),
            .d   (chain_q[g]),
            .q   (chain_q[g+1])
        );
    end
    assign out = chain_q[DEPTH];
endmodule

// File: tb/tb_siso_shift_reg.sv
// tb_siso_shift_reg: checks DEPTH=1/4/8 delay lines against a bit-history model
module tb_siso_shift_reg;
    logic clk, rst, din;
    logic o1, o4, o8;
    int checks = 0;
    int failures = 0;
    bit hist[$];

    siso_shift_reg #(.DEPTH(1)) u_d1 (.clk(clk), .rst(rst), .in(din), .out(o1));
    siso_shift_reg #(.DEPTH(4)) u_d4 (.clk(clk), .rst(rst), .in(din), .out(o4));
    siso_shift_reg #(.DEPTH(8)) u_d8 (.clk(clk), .rst(rst), .in(din), .out(o8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { bit in_b; bit exp_out; } vec_t;
    vec_t tbl[8];

    // out after the latest edge is the bit captured d edges earlier, or 0 if not yet reached
    function automatic bit model(int d);
        int n = hist.size();
        return (n >= d) ? hist[n-d] : 1'b0;
    endfunction

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, " d1"}, o1, model(1));
        chk({tag, " d4"}, o4, model(4));
        chk({tag, " d8"}, o8, model(8));
    endtask

    task automatic step(bit b);
        din = b;
        @(posedge clk);
        #1;
        hist.push_back(b);
    endtask

    task automatic pulse_reset(string tag);
        rst = 1'b1;
        #1;
        chk({tag, " async d1"}, o1, 1'b0);
        chk({tag, " async d4"}, o4, 1'b0);
        chk({tag, " async d8"}, o8, 1'b0);
        #1;
        rst = 1'b0;
        hist.delete();
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset held d1", o1, 1'b0);
            chk("reset held d4", o4, 1'b0);
            chk("reset held d8", o8, 1'b0);
        end
        rst = 1'b0;
        hist.delete();

        tbl = '{'{1,0}, '{1,0}, '{0,0}, '{1,1}, '{0,1}, '{0,0}, '{0,1}, '{0,0}};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].in_b);
            chk($sformatf("pattern edge%0d", i + 1), o4, tbl[i].exp_out);
            chk_all("pattern");
        end

        pulse_reset("latency");
        for (int i = 1; i <= 6; i++) begin
            step(i == 1);
            chk($sformatf("latency edge%0d", i), o4, i == 4);
            chk_all("latency");
        end

        pulse_reset("fill");
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            chk_all("fill");
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0);
            chk($sformatf("flush zero%0d", i), o4, i < 4);
            chk_all("flush");
        end

        pulse_reset("midreset pre");
        step(1); step(0); step(1); step(1);
        chk("midreset loaded", o4, 1'b1);
        pulse_reset("midreset");
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            chk("midreset drain d4", o4, 1'b0);
            chk_all("midreset drain");
        end

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset("random");
            step(1'($urandom));
            chk_all("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
